// File: rtl/game_pkg.sv
// Shared encodings for the battle controller: key codes, page codes, opcodes,
// move directions and the player-instruction packing helper.
package game_pkg;

    typedef enum logic [3:0] {
        KEY_IDLE  = 4'd0,
        KEY_W     = 4'd1,
        KEY_A     = 4'd2,
        KEY_S     = 4'd3,
        KEY_D     = 4'd4,
        KEY_J     = 4'd5,
        KEY_K     = 4'd6,
        KEY_L     = 4'd7,
        KEY_SPACE = 4'd8
    } key_e;

    typedef enum logic [3:0] {
        PG_MENU   = 4'h1,
        PG_WIN    = 4'h2,
        PG_DODGE  = 4'h9,
        PG_ATTACK = 4'hA,
        PG_ACTION = 4'hB
    } page_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_HPY = 4'd1,
        OP_DPY = 4'd2,
        OP_IDG = 4'd3,
        OP_SDG = 4'd4,
        OP_MOV = 4'd5,
        OP_SHP = 4'd6
    } op_e;

    typedef enum logic [1:0] {
        SEL_FIGHT = 2'd0,
        SEL_ITEM  = 2'd1,
        SEL_SKIP  = 2'd2,
        SEL_FLEE  = 2'd3
    } sel_e;

    localparam logic [7:0] DIR_UP    = 8'd0;
    localparam logic [7:0] DIR_LEFT  = 8'd1;
    localparam logic [7:0] DIR_DOWN  = 8'd2;
    localparam logic [7:0] DIR_RIGHT = 8'd3;

    function automatic logic [15:0] pack_instr(input op_e op, input logic [7:0] arg);
        return {op, arg, 4'h0};
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Turn timer: synchronous clear, count enable and a terminal-count compare
// that flags the last cycle of a turn.
module turn_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [TMR_W-1:0] i_tc,
    output logic             o_expire
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == i_tc);

endmodule

// File: rtl/battle_controller.sv
// Battle page/turn sequencer: menu navigation, timed dodge/attack turns,
// limited heal inventory and saturating monster-damage tracking.
module battle_controller
    import game_pkg::*;
#(
    parameter int unsigned HP_W       = 8,
    parameter int unsigned MON_HP_MAX = 100,
    parameter int unsigned HEAL_AMT   = 10,
    parameter int unsigned ITEM_COUNT = 3,
    parameter int unsigned DODGE_CYC  = 1000,
    parameter int unsigned ATK_CYC    = 500,
    parameter int unsigned TMR_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      key,
    input  logic            is_death,
    input  logic            atk_pass,
    input  logic [HP_W-1:0] dmg_mon,
    input  logic            dmg_complete,
    input  logic [7:0]      damage,
    input  logic            heal,
    output logic [7:0]      state,
    output logic [15:0]     player_instr,
    output logic            is_move,
    output logic            start_dmg,
    output logic [HP_W-1:0] mon_hp,
    output logic [3:0]      items_left
);

    localparam logic [3:0]       ITEMS_INIT = 4'(ITEM_COUNT);
    localparam logic [7:0]       HEAL8      = 8'(HEAL_AMT);
    localparam logic [HP_W-1:0]  HP_LIMIT   = HP_W'(MON_HP_MAX);
    localparam logic [TMR_W-1:0] DODGE_TC   = TMR_W'(DODGE_CYC - 1);
    localparam logic [TMR_W-1:0] ATK_TC     = TMR_W'(ATK_CYC - 1);

    page_e          r_page;
    logic [1:0]     r_sel;
    logic [3:0]     r_key_q;

    logic           w_press;
    logic           w_in_dodge;
    logic           w_in_atk;
    logic           w_expire;
    logic           w_tmr_clear;
    logic [TMR_W-1:0] w_tc;
    logic [HP_W:0]  w_hp_sum;
    logic [HP_W-1:0] w_hp_sat;
    logic [1:0]     w_sel_dec;
    logic [1:0]     w_sel_inc;
    logic           w_dir_valid;
    logic [7:0]     w_dir;

    assign w_press    = (key != KEY_IDLE) && (key != r_key_q);
    assign w_in_dodge = (r_page == PG_DODGE);
    assign w_in_atk   = (r_page == PG_ATTACK);
    assign w_sel_dec  = r_sel - 2'd1;
    assign w_sel_inc  = r_sel + 2'd1;
    assign w_tc       = w_in_dodge ? DODGE_TC : ATK_TC;

    // Timer sits at zero outside timed turns and is cleared on every exit,
    // so each DODGE/ATTACK entry starts counting from zero.
    assign w_tmr_clear = !(w_in_dodge || w_in_atk) || w_expire
                       || (w_in_atk && atk_pass) || (w_in_dodge && is_death);

    assign w_hp_sum = {1'b0, mon_hp} + {1'b0, dmg_mon};
    assign w_hp_sat = w_hp_sum[HP_W] ? '1 : w_hp_sum[HP_W-1:0];

    always_comb begin
        w_dir_valid = 1'b1;
        w_dir       = DIR_UP;
        case (key)
            KEY_W:   w_dir = DIR_UP;
            KEY_A:   w_dir = DIR_LEFT;
            KEY_S:   w_dir = DIR_DOWN;
            KEY_D:   w_dir = DIR_RIGHT;
            default: w_dir_valid = 1'b0;
        endcase
    end

    turn_timer #(
        .TMR_W (TMR_W)
    ) u_turn_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmr_clear),
        .i_en     (w_in_dodge || w_in_atk),
        .i_tc     (w_tc),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q <= '0;
        end else begin
            r_key_q <= key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page       <= PG_MENU;
            r_sel        <= '0;
            state        <= {PG_MENU, 4'h0};
            player_instr <= '0;
            is_move      <= 1'b0;
            start_dmg    <= 1'b0;
            mon_hp       <= '0;
            items_left   <= ITEMS_INIT;
        end else begin
            is_move   <= 1'b0;
            start_dmg <= 1'b0;
            case (r_page)
                PG_MENU: begin
                    state <= {PG_MENU, 4'h0};
                    if (w_press && key == KEY_SPACE) begin
                        r_page     <= PG_ACTION;
                        r_sel      <= '0;
                        state      <= {PG_ACTION, 4'h0};
                        mon_hp     <= '0;
                        items_left <= ITEMS_INIT;
                    end
                end
                PG_ACTION: begin
                    state <= {PG_ACTION, 2'b00, r_sel};
                    if (w_press) begin
                        case (key)
                            KEY_A: begin
                                r_sel <= w_sel_dec;
                                state <= {PG_ACTION, 2'b00, w_sel_dec};
                            end
                            KEY_D: begin
                                r_sel <= w_sel_inc;
                                state <= {PG_ACTION, 2'b00, w_sel_inc};
                            end
                            KEY_J: begin
                                case (r_sel)
                                    SEL_FIGHT: begin
                                        r_page <= PG_ATTACK;
                                        state  <= {PG_ATTACK, 4'h0};
                                    end
                                    SEL_ITEM: begin
                                        if (items_left != 4'd0) begin
                                            player_instr <= pack_instr(OP_HPY, HEAL8);
                                            start_dmg    <= 1'b1;
                                            items_left   <= items_left - 4'd1;
                                            r_page       <= PG_DODGE;
                                            state        <= {PG_DODGE, 4'h0};
                                        end
                                    end
                                    SEL_SKIP: begin
                                        r_page <= PG_DODGE;
                                        state  <= {PG_DODGE, 4'h0};
                                    end
                                    SEL_FLEE: begin
                                        r_page <= PG_MENU;
                                        state  <= {PG_MENU, 4'h0};
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                PG_DODGE: begin
                    state <= {PG_DODGE, 4'h0};
                    if (is_death) begin
                        r_page <= PG_MENU;
                        state  <= {PG_MENU, 4'h0};
                    end else begin
                        if (dmg_complete) begin
                            player_instr <= heal ? pack_instr(OP_HPY, HEAL8)
                                                 : pack_instr(OP_DPY, damage);
                            start_dmg    <= 1'b1;
                        end else if (w_dir_valid) begin
                            player_instr <= pack_instr(OP_MOV, w_dir);
                            is_move      <= 1'b1;
                        end else begin
                            player_instr <= '0;
                        end
                        if (w_expire) begin
                            r_page <= PG_ACTION;
                            state  <= {PG_ACTION, 2'b00, r_sel};
                        end
                    end
                end
                PG_ATTACK: begin
                    state <= {PG_ATTACK, 4'h0};
                    if (atk_pass) begin
                        mon_hp <= w_hp_sat;
                        if (w_hp_sat > HP_LIMIT) begin
                            r_page <= PG_WIN;
                            state  <= {PG_WIN, 4'h0};
                        end else begin
                            r_page <= PG_DODGE;
                            state  <= {PG_DODGE, 4'h0};
                        end
                    end else if (w_expire) begin
                        r_page <= PG_DODGE;
                        state  <= {PG_DODGE, 4'h0};
                    end
                end
                PG_WIN: begin
                    state        <= {PG_WIN, 4'h0};
                    player_instr <= '0;
                    if (w_press && key == KEY_SPACE) begin
                        r_page <= PG_MENU;
                        state  <= {PG_MENU, 4'h0};
                    end
                end
                default: begin
                    r_page <= PG_MENU;
                    state  <= {PG_MENU, 4'h0};
                end
            endcase
        end
    end

endmodule
